// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch port and the data port.
// Round-robin on contention; each access spans LATENCY cycles of mem_en followed by a one-cycle ack.
module mem_port_arbiter #(
  parameter int N        = 32,
  parameter int MEM_ADDR = 8,
  parameter int LATENCY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [MEM_ADDR-1:0] if_addr,
  output logic [N-1:0]        if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [MEM_ADDR-1:0] d_addr,
  input  logic [N-1:0]        d_wdata,
  output logic [N-1:0]        d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [MEM_ADDR-1:0] mem_addr,
  output logic [N-1:0]        mem_wdata,
  input  logic [N-1:0]        mem_rdata,
  output logic                stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state, state_next;
  logic [3:0]          cnt;
  logic                last_grant;
  logic                grant_d;
  logic                lat_we;
  logic [MEM_ADDR-1:0] lat_addr;
  logic [N-1:0]        lat_wdata;
  logic                grant_valid;
  logic                grant_to_d;

  // last_grant and grant_d encode the port: 0 = fetch, 1 = data
  always_comb begin
    grant_valid = (state == IDLE) && (if_req || d_req);
    grant_to_d  = d_req && (!if_req || !last_grant);
    state_next  = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      last_grant <= 1'b0;
      grant_d    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (grant_valid) begin
        grant_d    <= grant_to_d;
        last_grant <= grant_to_d;
        lat_we     <= grant_to_d && d_we;
        lat_addr   <= grant_to_d ? d_addr : if_addr;
        lat_wdata  <= grant_to_d ? d_wdata : '0;
        cnt        <= CNT_INIT;
      end else if (state == ACCESS) begin
        if (cnt == 4'd0) begin
          // writes leave both read-data registers untouched
          if (!lat_we) begin
            if (grant_d) d_rdata  <= mem_rdata;
            else         if_rdata <= mem_rdata;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign if_ack    = (state == DONE) && !grant_d;
  assign d_ack     = (state == DONE) && grant_d;
  assign stall     = (if_req && !if_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2 main instance plus LATENCY=1 and LATENCY=15 builds.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0]  if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall;
  logic [7:0]  mem_addr;

  logic        if_req1 = 1'b0, if_req15 = 1'b0;
  logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [31:0] if_rdata15, d_rdata15, mem_wdata15, mem_rdata15;
  logic        if_ack1, d_ack1, mem_en1, mem_we1, stall1;
  logic        if_ack15, d_ack15, mem_en15, mem_we15, stall15;
  logic [7:0]  mem_addr1, mem_addr15;

  logic [31:0] memArr [256];
  int          enRun = 0;
  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] expIf = '0, expD = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(32), .MEM_ADDR(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall));

  mem_port_arbiter #(.N(32), .MEM_ADDR(8), .LATENCY(1)) dutL1 (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(8'h33), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(32'h0), .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall(stall1));

  mem_port_arbiter #(.N(32), .MEM_ADDR(8), .LATENCY(15)) dutL15 (
    .clk(clk), .rst(rst), .if_req(if_req15), .if_addr(8'h55), .if_rdata(if_rdata15), .if_ack(if_ack15),
    .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(32'h0), .d_rdata(d_rdata15), .d_ack(d_ack15),
    .mem_en(mem_en15), .mem_we(mem_we15), .mem_addr(mem_addr15), .mem_wdata(mem_wdata15),
    .mem_rdata(mem_rdata15), .stall(stall15));

  // Memory model drives real data only in the last cycle of the enable window
  always @(posedge clk) begin
    if (rst) begin
      memArr[8'h04] <= 32'h00A00093;
      memArr[8'h20] <= 32'h12345678;
      memArr[8'h10] <= 32'h00000000;
      enRun <= 0;
    end else begin
      enRun <= mem_en ? enRun + 1 : 0;
      if (mem_en && mem_we) memArr[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata   = (mem_en && enRun == LAT - 1) ? memArr[mem_addr] : 32'hBAD0BAD0;
  assign mem_rdata1  = mem_en1  ? {24'hA1A1A1, mem_addr1}  : 32'hBAD0BAD0;
  assign mem_rdata15 = mem_en15 ? {24'hF1F1F1, mem_addr15} : 32'hBAD0BAD0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  // One complete access from an idle arbiter, checked cycle by cycle
  task automatic applyStimulus(input string tag, input bit isData, input bit we,
                               input logic [7:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata);
    if (isData) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < LAT; i++) begin
      waitEdge();
      checkOutput({tag, "_en"}, 32'(mem_en), 32'd1);
      checkOutput({tag, "_we"}, 32'(mem_we), 32'(we));
      checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      if (we) checkOutput({tag, "_wdata"}, mem_wdata, wdata);
      checkOutput({tag, "_earlyack"}, 32'(if_ack | d_ack), 32'd0);
      checkOutput({tag, "_stallbusy"}, 32'(stall), 32'd1);
    end
    waitEdge();
    if (!we) begin
      if (isData) expD = expRdata;
      else        expIf = expRdata;
    end
    checkOutput({tag, "_ifack"}, 32'(if_ack), 32'(!isData));
    checkOutput({tag, "_dack"}, 32'(d_ack), 32'(isData));
    checkOutput({tag, "_enoff"}, 32'(mem_en), 32'd0);
    checkOutput({tag, "_ifrdata"}, if_rdata, expIf);
    checkOutput({tag, "_drdata"}, d_rdata, expD);
    checkOutput({tag, "_stalldone"}, 32'(stall), 32'd0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    waitEdge();
    checkOutput({tag, "_ackpulse"}, 32'(if_ack | d_ack), 32'd0);
    checkOutput({tag, "_stallidle"}, 32'(stall), 32'd0);
  endtask

  initial begin
    int ack1Cyc, ack15Cyc, ack1Cnt, ack15Cnt;
    logic [31:0] rd1, rd15;

    #1;
    checkOutput("rst_en", 32'(mem_en), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_ack", 32'(if_ack | d_ack), 32'd0);
    checkOutput("rst_rdata", if_rdata | d_rdata, 32'd0);
    waitEdge();
    waitEdge();
    rst = 1'b0;

    applyStimulus("fetch", 1'b0, 1'b0, 8'h04, 32'h0, 32'h00A00093);
    applyStimulus("dread", 1'b1, 1'b0, 8'h20, 32'h0, 32'h12345678);
    applyStimulus("dwrite", 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0);
    applyStimulus("fetchwr", 1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);

    // Contention straight after reset goes to data first
    rst = 1'b1;
    waitEdge();
    rst = 1'b0;
    expIf = '0; expD = '0;
    if_req = 1'b1; if_addr = 8'h04;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    waitEdge();
    checkOutput("cont_daddr", 32'(mem_addr), 32'h20);
    waitEdge();
    waitEdge();
    checkOutput("cont_dack", 32'(d_ack), 32'd1);
    checkOutput("cont_noifack", 32'(if_ack), 32'd0);
    checkOutput("cont_drdata", d_rdata, 32'h12345678);
    checkOutput("cont_stallif", 32'(stall), 32'd1);
    d_req = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      waitEdge();
      checkOutput("cont_ifack", 32'(if_ack), 32'(c == 7));
      checkOutput("cont_stall", 32'(stall), 32'(c != 7));
      if (c == 5 || c == 6) checkOutput("cont_ifaddr", 32'(mem_addr), 32'h04);
    end
    checkOutput("cont_ifrdata", if_rdata, 32'h00A00093);
    if_req = 1'b0;
    waitEdge();

    // Sustained contention: last grant was fetch, so order is D, IF, D, IF
    if_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < LAT + 2; c++) begin
        waitEdge();
        checkOutput("rr_stall", 32'(stall), 32'd1);
        if (c == LAT) begin
          checkOutput("rr_dack", 32'(d_ack), 32'((g % 2) == 0));
          checkOutput("rr_ifack", 32'(if_ack), 32'((g % 2) == 1));
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    waitEdge();

    // Reset in the second cycle of an access loses it without an ack
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    waitEdge();
    waitEdge();
    rst = 1'b1;
    d_req = 1'b0;
    #1;
    checkOutput("rstmid_en", 32'(mem_en), 32'd0);
    checkOutput("rstmid_addr", 32'(mem_addr), 32'd0);
    checkOutput("rstmid_rdata", if_rdata | d_rdata, 32'd0);
    waitEdge();
    checkOutput("rstmid_ack", 32'(if_ack | d_ack), 32'd0);
    rst = 1'b0;
    waitEdge();
    checkOutput("rstmid_noack", 32'(if_ack | d_ack), 32'd0);
    expIf = '0; expD = '0;
    applyStimulus("postrst", 1'b1, 1'b0, 8'h20, 32'h0, 32'h12345678);

    // LATENCY=1 and LATENCY=15 builds, one fetch each
    ack1Cyc = -1; ack15Cyc = -1; ack1Cnt = 0; ack15Cnt = 0; rd1 = '0; rd15 = '0;
    if_req1 = 1'b1; if_req15 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      waitEdge();
      if (if_ack1) begin
        ack1Cnt++;
        if (ack1Cyc < 0) ack1Cyc = c;
        rd1 = if_rdata1;
        if_req1 = 1'b0;
      end
      if (if_ack15) begin
        ack15Cnt++;
        if (ack15Cyc < 0) ack15Cyc = c;
        rd15 = if_rdata15;
        if_req15 = 1'b0;
      end
    end
    checkOutput("l1_ackcyc", 32'(ack1Cyc), 32'd2);
    checkOutput("l1_ackcnt", 32'(ack1Cnt), 32'd1);
    checkOutput("l1_rdata", rd1, 32'hA1A1A133);
    checkOutput("l15_ackcyc", 32'(ack15Cyc), 32'd16);
    checkOutput("l15_ackcnt", 32'(ack15Cnt), 32'd1);
    checkOutput("l15_rdata", rd15, 32'hF1F1F155);
    checkOutput("lx_dside", d_rdata1 | d_rdata15 | mem_wdata1 | mem_wdata15, 32'd0);
    checkOutput("lx_dctl", 32'(d_ack1 | d_ack15 | mem_we1 | mem_we15 | stall1 | stall15), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
